// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM state, register address and status bit definitions (UART_RX_PARITY_EN adds the PARITY state)
package uart_pkg;

    localparam int FRAME_BITS = 8;

    localparam logic [31:0] RX_DATA_ADDR_DEF = 32'h0000_0810;
    localparam logic [31:0] RX_STAT_ADDR_DEF = 32'h0000_0814;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVR       = 2;
    localparam int STAT_FERR      = 3;
    localparam int STAT_PERR      = 4;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd4,
`endif
        RX_STOP   = 3'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - single-clock receive FIFO with combinational head
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = FRAME_BITS,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - memory-mapped UART receiver with FIFO, status register and level interrupt (UART_RX_PARITY_EN selects 8E1)
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int          BAUD_DIV     = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] RX_DATA_ADDR = RX_DATA_ADDR_DEF,
    parameter logic [31:0] RX_STAT_ADDR = RX_STAT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serialIn,
    input  logic        re,
    input  logic [31:0] address,
    output logic [31:0] dataOut,
    output logic        hit,
    output logic        Avail_out,
    output logic        Err_out
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    logic                  fall;

    rx_state_t             state;
    rx_state_t             state_next;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [BW-1:0]         bit_idx;
    logic [BW-1:0]         bit_next;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_next;
    logic                  push;
    logic                  set_ferr;
    logic                  set_ovr;

    logic                  ovr;
    logic                  ferr;
    logic                  perr;

    logic [FRAME_BITS-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [AW:0]           fifo_count;

    logic                  sel_data;
    logic                  sel_stat;
    logic                  pop;
    logic                  clr;

`ifdef UART_RX_PARITY_EN
    logic                  set_perr;
    logic                  par_bad;
    logic                  par_bad_next;
`endif

    assign fall = rx_prev & ~rx_sync;

    // Two-stage synchroniser plus one history stage for falling-edge detection; idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= serialIn;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit-timing counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_next;
`endif
        end
    end

    // Next-state logic: sample the line each time the counter expires, reload for the next bit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shreg_next = shreg;
        push       = 1'b0;
        set_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        set_perr     = 1'b0;
        par_bad_next = par_bad;
`endif
        if (state != RX_IDLE) begin
            cnt_next = (cnt == '0) ? FULL_LOAD : cnt - CW'(1);
        end
        case (state)
            RX_IDLE: begin
                if (fall) begin
                    state_next = RX_START;
                    cnt_next   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (rx_sync) begin
                        state_next = RX_IDLE;
                    end else begin
                        state_next = RX_DATA;
                        bit_next   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_next = 1'b0;
`endif
                    end
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shreg_next = {rx_sync, shreg[FRAME_BITS-1:1]};
                    bit_next   = bit_idx + BW'(1);
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt == '0) begin
                    state_next = RX_STOP;
                    if (rx_sync != ^shreg) begin
                        set_perr     = 1'b1;
                        par_bad_next = 1'b1;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (cnt == '0) begin
                    state_next = RX_IDLE;
                    if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                        push = ~par_bad;
`else
                        push = 1'b1;
`endif
                    end else begin
                        set_ferr = 1'b1;
                    end
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign sel_data = (address == RX_DATA_ADDR);
    assign sel_stat = (address == RX_STAT_ADDR);
    assign hit      = sel_data | sel_stat;
    assign pop      = re & sel_data & ~fifo_empty;
    assign clr      = re & sel_stat;
    assign set_ovr  = push & fifo_full & ~pop;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky error flags: a status read clears them, but a new error in the same cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= set_ovr  | (ovr  & ~clr);
            ferr <= set_ferr | (ferr & ~clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag, same clear rule as the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr <= 1'b0;
        end else begin
            perr <= set_perr | (perr & ~clr);
        end
    end
`else
    assign perr = 1'b0;
`endif

    // Read-data mux: data register, status register, or 0 when the address misses.
    always_comb begin
        dataOut = '0;
        if (sel_data) begin
            dataOut[FRAME_BITS]     = ~fifo_empty;
            dataOut[FRAME_BITS-1:0] = fifo_empty ? '0 : fifo_head;
        end else if (sel_stat) begin
            dataOut[STAT_NOT_EMPTY]             = ~fifo_empty;
            dataOut[STAT_FULL]                  = fifo_full;
            dataOut[STAT_OVR]                   = ovr;
            dataOut[STAT_FERR]                  = ferr;
            dataOut[STAT_PERR]                  = perr;
            dataOut[STAT_COUNT_LSB +: AW+1]     = fifo_count;
        end
    end

    assign Avail_out = ~fifo_empty;
    assign Err_out   = ovr | ferr | perr;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - randomized self-checking bench for uart_rx_mmio against a queue-based frame model
module tb_uart_rx_mmio;
    import uart_pkg::*;

    localparam int BAUD  = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_BUILT = 1'b1;
`else
    localparam bit PARITY_BUILT = 1'b0;
`endif
    // Posedges from the start-bit launch to the stop-bit sample edge.
    localparam int STOP_EDGE = BAUD / 2 + 3 + (PARITY_BUILT ? 10 : 9) * BAUD;

    logic        clk = 1'b0;
    logic        rst;
    logic        serialIn;
    logic        re;
    logic [31:0] address;
    logic [31:0] dataOut;
    logic        hit;
    logic        Avail_out;
    logic        Err_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_ferr;
    bit         m_perr;

    always #5 clk = ~clk;

    uart_rx_mmio #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serialIn  (serialIn),
        .re        (re),
        .address   (address),
        .dataOut   (dataOut),
        .hit       (hit),
        .Avail_out (Avail_out),
        .Err_out   (Err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data();
        return (q.size() != 0) ? {23'b0, 1'b1, q[0]} : 32'h0;
    endfunction

    function automatic logic [31:0] exp_stat();
        logic [7:0] c;
        c = 8'(q.size());
        return {16'b0, c, 3'b0, m_perr, m_ferr, m_ovr, q.size() == DEPTH, q.size() != 0};
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        bit par_bad;
        par_bad = PARITY_BUILT && !par_ok;
        if (par_bad)  m_perr = 1'b1;
        if (!stop_ok) m_ferr = 1'b1;
        if (stop_ok && !par_bad) begin
            if (q.size() < DEPTH) q.push_back(b);
            else                  m_ovr = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
    endfunction

    task automatic drive_bit(input logic v);
        serialIn = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic idle(input int n);
        serialIn = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PARITY_BUILT) drive_bit(par_ok ? ^b : ~(^b));
        drive_bit(stop_ok);
        serialIn = 1'b1;
        model_frame(b, stop_ok, par_ok);
    endtask

    task automatic rd_data(input string tag);
        address = RX_DATA_ADDR_DEF;
        re      = 1'b1;
        #1;
        check(tag, dataOut, exp_data());
        if (q.size() != 0) void'(q.pop_front());
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic rd_stat(input string tag);
        address = RX_STAT_ADDR_DEF;
        re      = 1'b1;
        #1;
        check(tag, dataOut, exp_stat());
        check({tag, "_err"}, {31'b0, Err_out}, {31'b0, m_ovr | m_ferr | m_perr});
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        @(negedge clk);
        re = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        model_reset();
        rst      = 1'b0;
        serialIn = 1'b1;
        re       = 1'b0;
        address  = RX_DATA_ADDR_DEF;
        repeat (3) @(negedge clk);
        check("reset_data",  dataOut, 32'h0);
        check("reset_hit",   {31'b0, hit}, 32'h1);
        check("reset_avail", {31'b0, Avail_out}, 32'h0);
        check("reset_err",   {31'b0, Err_out}, 32'h0);
        rst = 1'b1;
        idle(5);
        rd_stat("reset_stat");

        // Single frame with interrupt timing around the stop sample.
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (STOP_EDGE - 3) @(negedge clk);
                check("a5_avail_early", {31'b0, Avail_out}, 32'h0);
                repeat (5) @(negedge clk);
                check("a5_avail_late", {31'b0, Avail_out}, 32'h1);
            end
        join
        idle(4);
        check("a5_word_model", exp_data(), 32'h0000_01A5);
        rd_data("a5_data");
        check("a5_avail_after_pop", {31'b0, Avail_out}, 32'h0);
        rd_data("a5_empty");

        // Short and sub-half-bit glitches must not start a frame.
        serialIn = 1'b0;
        @(negedge clk);
        idle(20);
        serialIn = 1'b0;
        repeat (7) @(negedge clk);
        idle(30);
        check("glitch_avail", {31'b0, Avail_out}, 32'h0);
        rd_stat("glitch_stat");
        send_frame(8'h96, 1'b1, 1'b1);
        idle(4);
        rd_data("post_glitch");

        // Framing error.
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(4);
        check("ferr_avail", {31'b0, Avail_out}, 32'h0);
        rd_stat("ferr_stat");
        rd_stat("ferr_cleared");

        // Overflow: five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b1);
            idle(2);
        end
        check("ovr_stat_model", exp_stat(), 32'h0000_0407);
        rd_stat("ovr_stat");
        for (int i = 0; i < 5; i++) rd_data($sformatf("ovr_data%0d", i));

        // Pop on the same edge as the push into a full FIFO.
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1, 1'b1);
            idle(2);
        end
        fork
            send_frame(8'h15, 1'b1, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                rd_data("simul_pop");
            end
        join
        idle(4);
        check("simul_stat_model", exp_stat(), 32'h0000_0403);
        rd_stat("simul_stat");
        for (int i = 0; i < 5; i++) rd_data($sformatf("simul_data%0d", i));

        // Reset in the middle of data bit 3 with a byte already queued.
        send_frame(8'h77, 1'b1, 1'b1);
        idle(2);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        serialIn = 1'b0;
        repeat (BAUD / 2) @(negedge clk);
        rst      = 1'b0;
        serialIn = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_avail", {31'b0, Avail_out}, 32'h0);
        rst = 1'b1;
        idle(20);
        rd_stat("rst_stat_empty");
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(4);
        rd_stat("rst_stat_one");
        rd_data("rst_data");
        rd_data("rst_empty");

        if (PARITY_BUILT) begin
            send_frame(8'h5A, 1'b1, 1'b0);
            idle(4);
            check("perr_avail", {31'b0, Avail_out}, 32'h0);
            rd_stat("perr_stat");
        end

        // Randomized mix of frames, bad frames, reads and address misses.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                send_frame(8'($urandom), 1'b1, 1'b1);
                idle($urandom_range(1, 6));
            end else if (r == 5) begin
                send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                idle(4);
            end else if (r <= 7) begin
                rd_data($sformatf("rnd_data%0d", n));
            end else if (r == 8) begin
                rd_stat($sformatf("rnd_stat%0d", n));
            end else begin
                a = $urandom;
                if (a == RX_DATA_ADDR_DEF || a == RX_STAT_ADDR_DEF) a = a ^ 32'h1000;
                address = a;
                re      = 1'b0;
                #1;
                check($sformatf("rnd_miss_hit%0d", n), {31'b0, hit}, 32'h0);
                check($sformatf("rnd_miss_data%0d", n), dataOut, 32'h0);
                @(negedge clk);
            end
        end
        rd_stat("final_stat");
        while (q.size() != 0) rd_data("drain");
        rd_data("final_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver: the receive side of the SoC's serial link, complementing the existing transmit path. It deserialises 8-bit frames from the `serialIn` pin, buffers them in a small FIFO, and exposes data and status registers on the MIPS data-memory bus (`dmem_addr`/`rd_dm` side). A level interrupt indicates pending data and is intended for one of the free `INT[3:1]` lines of the core.

## Interface
- `BAUD_DIV`, 868: `clk` cycles per bit (100 MHz / 115200); minimum 4.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, 2..64.
- `RX_DATA_ADDR`, 32'h0000_0810: byte address of the data register.
- `RX_STAT_ADDR`, 32'h0000_0814: byte address of the status register.
- `clk  in  1`: system clock; the only clock in the block.
- `rst  in  1`: asynchronous, active-low reset.
- `serialIn  in  1`: asynchronous RX line; idles high.
- `re  in  1`: bus read strobe, qualified by `address`.
- `address  in  32`: bus address, equivalent to `dmem_addr`.
- `dataOut  out  32`: combinational read data; 0 when `hit`=0.
- `hit  out  1`: `address` equals RX_DATA_ADDR or RX_STAT_ADDR.
- `Avail_out  out  1`: level interrupt; FIFO not empty.
- `Err_out  out  1`: OR of the sticky error flags.

## Operation
- `serialIn` passes through a 2-FF synchroniser, reset to 1. Falling-edge detection uses the synchronised value and its previous value.
- Receiver FSM states are IDLE, START, DATA, STOP, plus PARITY when the parity macro is defined.
  - IDLE: on a detected falling edge, go to START and load the bit counter with BAUD_DIV/2 − 1.
  - START: when the counter reaches 0, sample the line. A 1 is a glitch: return to IDLE with no flags set. A 0 moves to DATA with the counter at BAUD_DIV − 1 and bit index 0.
  - DATA: sample at each counter expiry and shift into the byte LSB-first. After bit 7, go to STOP (or PARITY).
  - STOP: sample at counter expiry. A 1 pushes the byte. A 0 sets `ferr` sticky and discards the byte. Return to IDLE in either case; a held-low line (break) therefore cannot re-trigger until it rises and falls again.
- FIFO push when full: the byte is dropped and `ovr` sticky is set.
- Data register (RX_DATA_ADDR):
  - Read value is {23'b0, valid, byte}. `valid` = FIFO not empty; `byte` = FIFO head, or 0 when empty.
  - `re`=1 at a clock edge with a valid head pops one entry. A read while empty has no side effect.
- Status register (RX_STAT_ADDR):
  - Bits: [0] not-empty, [1] full, [2] `ovr`, [3] `ferr`, [4] `perr` (0 if parity is compiled out), [15:8] count, [31:16] 0.
  - A `re` read clears `ovr`, `ferr` and `perr` at that edge. An error set in the same cycle as the clear wins and stays set.
- Push and pop in the same cycle: both take effect and the count is unchanged. When full, a simultaneous pop frees the slot, so there is no overrun.
- Reset mid-frame: the FSM goes to IDLE, the FIFO empties, flags clear, and the partial byte is lost.

## Timing
- All outputs after reset: `dataOut`=0, `hit` decoded from `address`, `Avail_out`=0, `Err_out`=0. FSM in IDLE, count 0.
- Start sample lands BAUD_DIV/2 + 2 cycles after the line falls (2 cycles of synchroniser).
- Each subsequent sample follows the previous one by exactly BAUD_DIV cycles.
- Pushed byte is visible in `dataOut` and `Avail_out` rises 1 cycle after the stop-bit sample edge.
- `dataOut` is combinational from `address` and FIFO/flag state. Pop and flag clear take effect at the `re` edge; a read in the following cycle sees the new state.
- Counter width is clog2(BAUD_DIV). The counter reloads on expiry and never wraps past 0.
- FIFO pointers are clog2(FIFO_DEPTH) bits and wrap modulo depth. Count is one bit wider.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frames are 8E1: a PARITY state after DATA samples an even-parity bit.
  - On mismatch, `perr` is set and the byte is discarded; the STOP check still runs.
  - Start-to-push latency grows by BAUD_DIV.
- Undefined: frames are 8N1, there is no PARITY state, and status bit 4 reads 0.

## Structure
- Shared package `uart_pkg`, also used by the transmit path, holds:
  - the FSM state enum;
  - the register address defaults;
  - the status bit-index constants;
  - the frame width constant (8).
- One sub-module, `uart_rx_fifo`: synchronous single-clock FIFO, parameterised on depth and width, with push, pop, full, empty, count and combinational head.

## Test plan
- Bench settings for all scenarios: BAUD_DIV=16, FIFO_DEPTH=4.
- Send frame 0xA5 (8N1) → `Avail_out` rises 1 cycle after the stop sample. Data read returns 32'h0000_01A5. After the pop, `Avail_out`=0 and the data register reads 0.
- 1-cycle-low then 7-cycle-low glitches on an idle line → no push, no flags, FSM back in IDLE.
- Frame with stop bit 0 (byte 0x3C) → no push, status reads 32'h0000_0008, `Err_out`=1. A second status read returns 0.
- Send 5 frames (0x01..0x05) with no reads → count=4, full=1, `ovr`=1. Data reads return 0x01..0x04, then valid=0.
- FIFO full with a pop landing on the same cycle as the 5th frame's push → count stays 4, `ovr`=0, and the head order is preserved.
- Assert `rst` at DATA bit 3, release it, then send 0x5A → exactly one byte (0x5A) is received. With `UART_RX_PARITY_EN` defined, sending 0x5A with wrong parity sets `perr` and pushes nothing.
